// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_timer_pkg
// Brief    : Shared state encoding and BCD digit limits for the BCD timer.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_timer_pkg;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/tick_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : tick_sync_edge
// Brief    : Multi-flop synchronizer followed by a rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A held-high level gives one pulse because r_prev catches up a cycle later
    assign rise_out = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/bcd_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_timer
// Brief    : MM:SS BCD timer advanced by rising edges of a divided clock level.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    logic       w_rise;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_inc;
    logic       w_c0, w_c1, w_c2, w_c3;
    logic [3:0] r_so, r_st, r_mo, r_mt;
    logic [3:0] w_so_next, w_st_next, w_mo_next, w_mt_next;
    logic       r_wrap;

    tick_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (tick_in),
        .rise_out (w_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_STOP;
        end else if (start_stop) begin
            w_state_next = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    // Increment decision uses the pre-transition state, so a stop request still counts
    assign w_inc = w_rise & (r_state == ST_RUN) & ~clear;
    assign w_c0  = w_inc & (r_so == ONES_MAX);
    assign w_c1  = w_c0  & (r_st == TENS_MAX);
    assign w_c2  = w_c1  & (r_mo == ONES_MAX);
    assign w_c3  = w_c2  & (r_mt == TENS_MAX);

    always_comb begin
        w_so_next = r_so;
        w_st_next = r_st;
        w_mo_next = r_mo;
        w_mt_next = r_mt;
        if (w_inc) begin
            w_so_next = w_c0 ? 4'd0 : r_so + 4'd1;
        end
        if (w_c0) begin
            w_st_next = w_c1 ? 4'd0 : r_st + 4'd1;
        end
        if (w_c1) begin
            w_mo_next = w_c2 ? 4'd0 : r_mo + 4'd1;
        end
        if (w_c2) begin
            w_mt_next = w_c3 ? 4'd0 : r_mt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_so   <= 4'd0;
            r_st   <= 4'd0;
            r_mo   <= 4'd0;
            r_mt   <= 4'd0;
            r_wrap <= 1'b0;
        end else if (clear) begin
            r_so   <= 4'd0;
            r_st   <= 4'd0;
            r_mo   <= 4'd0;
            r_mt   <= 4'd0;
            r_wrap <= 1'b0;
        end else begin
            r_so   <= w_so_next;
            r_st   <= w_st_next;
            r_mo   <= w_mo_next;
            r_mt   <= w_mt_next;
            r_wrap <= w_c3;
        end
    end

    assign sec_ones = r_so;
    assign sec_tens = r_st;
    assign min_ones = r_mo;
    assign min_tens = r_mt;
    assign running  = (r_state == ST_RUN);
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_timer
// Brief    : Randomized self-checking bench for bcd_timer with a seconds-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timer;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, wrap;
    logic [15:0] digits;

    int total = 0;
    int bad   = 0;

    // Model: elapsed seconds 0..3599, run flag, wrap flag, recent tick samples
    int m_cnt  = 0;
    bit m_run  = 1'b0;
    bit m_wrap = 1'b0;
    bit hist [N+1];

    bcd_timer #(
        .SYNC_STAGES (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int c);
        int s, m;
        s = c % 60;
        m = c / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A rise is seen N edges after the first high sample, provided the sample before it was low
    initial begin
        bit rise;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt  = 0;
                m_run  = 1'b0;
                m_wrap = 1'b0;
                for (int i = 0; i <= N; i++) hist[i] = 1'b0;
            end else begin
                rise = hist[N-1] && !hist[N];
                for (int i = N; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = tick_in;
                if (clear) begin
                    m_cnt  = 0;
                    m_run  = 1'b0;
                    m_wrap = 1'b0;
                end else begin
                    m_wrap = rise && m_run && (m_cnt == 3599);
                    if (rise && m_run) m_cnt = (m_cnt + 1) % 3600;
                    if (start_stop) m_run = !m_run;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("model", {14'd0, digits, running, wrap},
                      {14'd0, bcd(m_cnt), m_run, m_wrap});
            end
        end
    end

    // All driver tasks start and end just after a falling edge
    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic tick(input int h, input int l, input bit rnd);
        tick_in = 1'b1;
        repeat (h) begin
            if (rnd) begin
                start_stop = ($urandom_range(0, 7) == 0);
                clear      = ($urandom_range(0, 39) == 0);
            end
            @(negedge clk);
        end
        start_stop = 1'b0;
        clear      = 1'b0;
        tick_in    = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick(N, N, 1'b0);
    endtask

    // Raise tick_in and assert a control so it lands on the same edge as the increment
    task automatic coincide(input bit use_clear);
        tick_in = 1'b1;
        repeat (N) @(negedge clk);
        if (use_clear) clear = 1'b1;
        else start_stop = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        tick_in    = 1'b0;
        repeat (N + 1) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hold_digits", {16'd0, digits}, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {14'd0, digits, running, wrap}, 32'h0);

        // Basic run with explicit latency
        pulse_ss();
        check("running_after_start", {31'd0, running}, 32'd1);
        tick_in = 1'b1;
        repeat (N) @(negedge clk);
        check("latency_before", {16'd0, digits}, 32'h0000);
        @(negedge clk);
        check("latency_after", {16'd0, digits}, 32'h0001);
        tick_in = 1'b0;
        repeat (N) @(negedge clk);
        run_ticks(8);
        check("count_09", {16'd0, digits}, 32'h0009);
        run_ticks(1);
        check("carry_09_10", {16'd0, digits}, 32'h0010);
        tick(50, N, 1'b0);
        check("long_high_once", {16'd0, digits}, 32'h0011);
        run_ticks(48);
        check("count_59", {16'd0, digits}, 32'h0059);
        run_ticks(1);
        check("carry_59_100", {16'd0, digits}, 32'h0100);

        // Random tick shapes with occasional start_stop and clear
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 19))
                0:       do_clear();
                1, 2:    pulse_ss();
                default: tick($urandom_range(N, N + 4), $urandom_range(N, N + 4), 1'b1);
            endcase
        end

        // Rollover
        do_clear();
        pulse_ss();
        run_ticks(3599);
        check("count_5959", {16'd0, digits}, 32'h5959);
        tick_in = 1'b1;
        repeat (N) @(negedge clk);
        check("wrap_before", {31'd0, wrap}, 32'd0);
        @(negedge clk);
        check("wrap_pulse", {14'd0, digits, running, wrap}, {14'd0, 16'h0000, 2'b11});
        @(negedge clk);
        check("wrap_one_cycle", {31'd0, wrap}, 32'd0);
        tick_in = 1'b0;
        repeat (N) @(negedge clk);

        // Clear coinciding with an increment
        do_clear();
        pulse_ss();
        run_ticks(7);
        check("count_07", {16'd0, digits}, 32'h0007);
        coincide(1'b1);
        check("clear_vs_tick", {15'd0, digits, running}, {15'd0, 16'h0000, 1'b0});
        run_ticks(2);
        check("stopped_after_clear", {16'd0, digits}, 32'h0000);

        // start_stop coinciding with an increment, from RUN then from STOP
        pulse_ss();
        run_ticks(3);
        check("count_03", {16'd0, digits}, 32'h0003);
        coincide(1'b0);
        check("ss_tick_run", {15'd0, digits, running}, {15'd0, 16'h0004, 1'b0});
        coincide(1'b0);
        check("ss_tick_stop", {15'd0, digits, running}, {15'd0, 16'h0004, 1'b1});

        // Asynchronous reset mid-count
        do_clear();
        pulse_ss();
        run_ticks(754);
        check("count_1234", {16'd0, digits}, 32'h1234);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {14'd0, digits, running, wrap}, 32'h0);
        @(negedge clk);

        // Reset release with tick_in already high
        tick_in = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("release_tick_high", {15'd0, digits, running}, 32'h0);
        pulse_ss();
        tick_in = 1'b0;
        repeat (N + 1) @(negedge clk);
        run_ticks(1);
        check("first_genuine_edge", {15'd0, digits, running}, {15'd0, 16'h0001, 1'b1});

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_timer.md
# bcd_timer

Minutes:seconds BCD timer that consumes the divided clock level produced by the upstream clock divider, for example a 1 Hz `clkout`. It runs entirely in the system clock domain. It synchronizes the divided level, detects its rising edge, and uses each detected edge as a count enable for a 00:00–59:59 BCD counter. The digits feed the downstream seven-segment scanner.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `tick_in` synchronizer chain; legal values are 2 or greater.

Ports:
- `clk`  in  1  system clock; all state is clocked on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tick_in`  in  1  divided clock level from the divider; may be asynchronous to `clk`.
- `start_stop`  in  1  one-cycle pulse that toggles between STOP and RUN.
- `clear`  in  1  synchronous clear: zeroes all digits and forces STOP.
- `sec_ones`  out  4  BCD seconds units, 0–9.
- `sec_tens`  out  4  BCD seconds tens, 0–5.
- `min_ones`  out  4  BCD minutes units, 0–9.
- `min_tens`  out  4  BCD minutes tens, 0–5.
- `running`  out  1  high while the state is RUN.
- `wrap`  out  1  one-cycle pulse on the 59:59 → 00:00 rollover.

## Operation
- Tick path:
  - `tick_in` passes through the `SYNC_STAGES` flops `s[0..N-1]`.
  - A `prev` register holds `s[N-1]` delayed by one cycle.
  - `rise = s[N-1] & ~prev`, exactly one cycle per low-to-high transition of `tick_in`.
  - A level held high for any duration yields a single `rise`.
- FSM states:
  - STOP (reset state) and RUN.
  - `start_stop` toggles the state. `clear` forces STOP.
  - Priority: `clear` > `start_stop`.
- Count, applied when `rise` is high and the current (pre-transition) state is RUN:
  - `sec_ones` +1; at 9 it goes to 0 and carries into `sec_tens`.
  - `sec_tens` at 5 with an incoming carry goes to 0 and carries into `min_ones`.
  - `min_ones` at 9 with a carry goes to 0 and carries into `min_tens`.
  - `min_tens` at 5 with a carry goes to 0, and `wrap` pulses in the same update.
- Digit values above their maxima are unreachable and need not be handled.
- Simultaneous events:
  - `clear` with `rise`: no increment; digits become 0, state STOP.
  - `start_stop` with `rise` while in RUN: the increment happens, then the state becomes STOP.
  - `start_stop` with `rise` while in STOP: no increment, state becomes RUN.
  - `clear` with `start_stop`: state STOP, digits 0.
- STOP holds all digits. `rise` events during STOP are discarded, not queued.

## Timing
- Reset, asynchronous and immediate, including mid-count:
  - Synchronizer flops and `prev` go to 0.
  - All digits go to 0.
  - `running` goes to 0 and `wrap` goes to 0.
  - State goes to STOP.
- Because `prev` resets to 0, a `tick_in` already high at reset release produces one `rise`. It is ignored because the state is STOP.
- Tick latency: if `tick_in` is first sampled high at clock edge k, the digits update at edge k+`SYNC_STAGES`.
- Control latency:
  - `start_stop` or `clear` asserted in cycle k takes effect at edge k+1.
  - `running` is registered, so it reflects the new state from edge k+1.
- `wrap` is high for exactly the one cycle following the rollover edge. It is registered, not combinational.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Throughput: at most one increment per 2×`SYNC_STAGES` cycles is guaranteed, because `tick_in` is assumed slower than that.

## Structure
- Package `bcd_timer_pkg` holds:
  - The state encoding constants `ST_STOP` = 1'b0 and `ST_RUN` = 1'b1.
  - The digit limit constants `ONES_MAX` = 9 and `TENS_MAX` = 5.
- One sub-module, `tick_sync_edge`:
  - Parameterized by `SYNC_STAGES`.
  - Ports `clk`, `rst_n`, `async_in`, `rise_out`.
  - It is reused by the key and debounce blocks.
- The top level contains the FSM and the four-digit BCD chain.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-count at 12:34 → all digits 0, `running` 0, `wrap` 0 immediately, without waiting for a clock edge.
- **Basic run and latency.** Pulse `start_stop`, then apply 10 `tick_in` rising edges → digits read 00:10. Each increment appears `SYNC_STAGES` edges after `tick_in` is first sampled high. `tick_in` held high for 50 cycles counts once.
- **Rollover.** Count to 59:59, then apply one tick → 00:00, `wrap` high for exactly one cycle, `running` still 1. Also check the 09 → 10 and 59 → 1:00 carries.
- **Clear versus tick.** In RUN at 00:07, assert `clear` in the same cycle as `rise` → 00:00, STOP. Later ticks leave 00:00 unchanged.
- **start_stop versus tick.**
  - In RUN at 00:03, `start_stop` coinciding with `rise` → 00:04, STOP.
  - In STOP, the same coincidence → 00:04 unchanged, RUN.
- **Reset release with `tick_in` high.** Release `rst_n` while `tick_in` = 1 → no count. Then pulse `start_stop`; the next genuine edge gives 00:01.
